// File: rtl/bus_divider_slave_if.sv
// Bus port bundle between the CDC stage (master) and the divider slave.
// bus_address is nonzero for exactly one cycle per access; module_busy falls when the access completes.
interface bus_divider_slave_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    logic [AddressWidth-1:0] bus_address;
    logic                    bus_we;
    logic [DataWidth-1:0]    bus_data_w;
    logic [DataWidth-1:0]    bus_data_r;
    logic                    module_busy;

    modport master (
        output bus_address, bus_we, bus_data_w,
        input  bus_data_r, module_busy
    );

    modport slave (
        input  bus_address, bus_we, bus_data_w,
        output bus_data_r, module_busy
    );
endinterface

// File: rtl/bus_divider_slave.sv
// Memory-mapped restoring divider, one quotient bit per cycle, busy-pulse completion signalling.
// Optional signed start at offset 5 is enabled by defining BUS_DIVIDER_SIGNED_EN.
module bus_divider_slave #(
    parameter int                      AddressWidth = 32,
    parameter int                      DataWidth    = 32,
    parameter logic [AddressWidth-1:0] BaseAddress  = AddressWidth'(32'h0000_9000)
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    bus_divider_slave_if.slave  bus,
    output logic [1:0]          dbg_state_o
);
    localparam int N  = DataWidth;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    state_e          state_q;
    logic            busy_q;
    logic [N-1:0]    rdata_q;
    logic [N-1:0]    dividend_q;
    logic [N-1:0]    divisor_q;
    logic [N-1:0]    quotient_q;
    logic [N-1:0]    remainder_q;
    logic            done_q;
    logic            dbz_q;
    logic            signed_q;
    logic            zero_q;
    logic [N-1:0]    rem_q;
    logic [N-1:0]    dvd_q;
    logic [N-1:0]    dsr_q;
    logic [CW-1:0]   cnt_q;
    logic            qneg_q;
    logic            rneg_q;

    logic [AddressWidth-1:0] offset;
    logic                    hit;
    logic [2:0]              sel;
    logic [N-1:0]            rd_mux;
    logic                    start_w;
    logic                    start_signed_w;
    logic                    qneg_w;
    logic                    rneg_w;
    logic [N-1:0]            op_dvd_w;
    logic [N-1:0]            op_dsr_w;
    logic [N:0]              trial_d;
    logic [N:0]              diff_d;
    logic                    take_d;

    assign offset = bus.bus_address - BaseAddress;
    assign hit    = (bus.bus_address >= BaseAddress) && (offset <= AddressWidth'(5));
    assign sel    = offset[2:0];

`ifdef BUS_DIVIDER_SIGNED_EN
    // Signed divides run on magnitudes; the result signs are restored in FIX.
    assign start_signed_w = bus.bus_we && (sel == 3'd5);
    assign rneg_w         = start_signed_w && dividend_q[N-1];
    assign qneg_w         = start_signed_w && (dividend_q[N-1] ^ bus.bus_data_w[N-1]);
    assign op_dvd_w       = rneg_w ? -dividend_q : dividend_q;
    assign op_dsr_w       = (start_signed_w && bus.bus_data_w[N-1]) ? -bus.bus_data_w
                                                                    : bus.bus_data_w;
`else
    assign start_signed_w = 1'b0;
    assign rneg_w         = 1'b0;
    assign qneg_w         = 1'b0;
    assign op_dvd_w       = dividend_q;
    assign op_dsr_w       = bus.bus_data_w;
`endif

    assign start_w = bus.bus_we && ((sel == 3'd1) || start_signed_w);

    always_comb begin
        rd_mux = '0;
        case (sel)
            3'd0:    rd_mux = dividend_q;
            3'd1:    rd_mux = divisor_q;
            3'd2:    rd_mux = quotient_q;
            3'd3:    rd_mux = remainder_q;
            3'd4:    rd_mux = {{(N-3){1'b0}}, signed_q, dbz_q, done_q};
            default: rd_mux = '0;
        endcase
    end

    // The remainder stays below the divisor, so bit N of the difference is a pure borrow flag.
    assign trial_d = {rem_q, dvd_q[N-1]};
    assign diff_d  = trial_d - {1'b0, dsr_q};
    assign take_d  = ~diff_d[N];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            signed_q    <= 1'b0;
            zero_q      <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        busy_q  <= 1'b1;
                        state_q <= S_ACK;
                        if (!bus.bus_we) begin
                            rdata_q <= rd_mux;
                        end else begin
                            rdata_q <= '0;
                            if (sel == 3'd0) begin
                                dividend_q <= bus.bus_data_w;
                            end
                            if (start_w) begin
                                divisor_q <= bus.bus_data_w;
                                done_q    <= 1'b0;
                                signed_q  <= start_signed_w;
                                if (bus.bus_data_w == '0) begin
                                    zero_q <= 1'b1;
                                end else begin
                                    state_q <= S_DIV;
                                    rem_q   <= '0;
                                    dvd_q   <= op_dvd_w;
                                    dsr_q   <= op_dsr_w;
                                    cnt_q   <= '0;
                                    qneg_q  <= qneg_w;
                                    rneg_q  <= rneg_w;
                                end
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (zero_q) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_q;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                        zero_q      <= 1'b0;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_DIV: begin
                    rem_q <= take_d ? diff_d[N-1:0] : trial_d[N-1:0];
                    dvd_q <= {dvd_q[N-2:0], take_d};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(N-1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient_q  <= qneg_q ? -dvd_q : dvd_q;
                    remainder_q <= rneg_q ? -rem_q : rem_q;
                    done_q      <= 1'b1;
                    dbz_q       <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.bus_data_r  = rdata_q;
    assign bus.module_busy = busy_q;
    assign dbg_state_o     = state_q;
endmodule
